stream_mux_arb: RTL and testbench

Parametrised N-channel streaming multiplexer with a valid/ready handshake, a registered output stage and per-packet channel locking. Channel selection is fixed, round-robin or fixed-priority. It replaces the purely combinational wide multiplexer trees wherever several producers share one downstream consumer. It sits between channel sources (DMA/UART/test-pattern streams) and a single sink such as an output FIFO or transmitter.

---
 rtl/stream_mux_arb.sv | 150 +++++++++++++++
 tb/tb_stream_mux_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Channel choice is fixed, round-robin or priority, and held for a whole packet.
module stream_mux_arb #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 16,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS*WIDTH-1:0] in_data_i,
    input  logic [CHANNELS-1:0]       in_valid_i,
    input  logic [CHANNELS-1:0]       in_last_i,
    output logic [CHANNELS-1:0]       in_ready_o,
    input  logic [1:0]                mode_i,
    input  logic [SEL_W-1:0]          select_i,
    output logic [WIDTH-1:0]          out_data_o,
    output logic                      out_last_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SEL_W-1:0]          grant_o
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   grant_q, grant_d;

    logic               ld;
    logic               cand_ok;
    logic               xfer;
    logic [SEL_W-1:0]   cand;
    logic [SEL_W-1:0]   idx;
    logic [WIDTH-1:0]   beat_data;
    logic               beat_last;

    always_comb begin
        ld      = !out_valid_q || out_ready_i;
        cand    = '0;
        cand_ok = 1'b0;
        idx     = '0;

        if (state_q == StLocked) begin
            cand    = lock_ch_q;
            cand_ok = 1'b1;
        end else begin
            case (mode_i)
                2'b00: begin
                    cand    = select_i;
                    cand_ok = (32'(select_i) < CHANNELS);
                end
                2'b01: begin
                    // Search upward from the channel after the last packet's owner.
                    for (int unsigned i = 1; i <= CHANNELS; i++) begin
                        idx = SEL_W'((32'(rr_ptr_q) + i) % CHANNELS);
                        if (!cand_ok && in_valid_i[idx]) begin
                            cand    = idx;
                            cand_ok = 1'b1;
                        end
                    end
                end
                2'b10: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        idx = SEL_W'(i);
                        if (!cand_ok && in_valid_i[idx]) begin
                            cand    = idx;
                            cand_ok = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        in_ready_o = '0;
        if (ld && cand_ok && !rst_i) begin
            in_ready_o[cand] = 1'b1;
        end

        xfer      = ld && cand_ok && !rst_i && in_valid_i[cand];
        beat_data = in_data_i[32'(cand)*WIDTH +: WIDTH];
        beat_last = in_last_i[cand];
    end

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        grant_d     = grant_q;

        if (xfer) begin
            out_data_d  = beat_data;
            out_last_d  = beat_last;
            grant_d     = cand;
            out_valid_d = 1'b1;
            if (beat_last) begin
                rr_ptr_d = cand;
            end
            case (state_q)
                StIdle: begin
                    if (!beat_last) begin
                        state_d   = StLocked;
                        lock_ch_d = cand;
                    end
                end
                StLocked: begin
                    if (beat_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (ld) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lock_ch_q   <= '0;
            rr_ptr_q    <= SEL_W'(CHANNELS - 1);
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb (16 channels x 8 bits).
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_stream_mux_arb;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 16;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS-1:0]       in_ready;
    logic [1:0]                mode;
    logic [3:0]                select;
    logic [WIDTH-1:0]          out_data;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [3:0]                grant;

    int checks = 0;
    int errors = 0;

    stream_mux_arb #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_last_i  (in_last),
        .in_ready_o (in_ready),
        .mode_i     (mode),
        .select_i   (select),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .grant_o    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic [7:0] d, input logic l);
        in_valid[c]            = v;
        in_data[c*WIDTH +: WIDTH] = d;
        in_last[c]             = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        mode      = 2'b10;
        select    = '0;
        out_ready = 1'b1;
        tick();
        set_ch(3, 1'b1, 8'h33, 1'b1);
        #1;
        checks++;
        if (in_ready !== 16'h0000) begin
            errors++;
            $display("FAIL reset_in_ready_during_rst: got %h expected %h", in_ready, 16'h0000);
        end
        set_ch(3, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 16'h0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %h expected %h", in_ready, 16'h0000);
        end
        checks++;
        if (grant !== 4'd0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%0d data=%h last=%b expected 0/00/0",
                     grant, out_data, out_last);
        end
    endtask

    task automatic test_fixed_select();
        mode   = 2'b00;
        select = 4'd5;
        set_ch(5, 1'b1, 8'hA5, 1'b1);
        #1;
        checks++;
        if (in_ready !== 16'h0020) begin
            errors++;
            $display("FAIL fixed_in_ready: got %h expected %h", in_ready, 16'h0020);
        end
        tick();
        set_ch(5, 1'b0, 8'h00, 1'b0);
        checks++;
        if (out_data !== 8'hA5 || grant !== 4'd5 || out_valid !== 1'b1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL fixed_beat: got data=%h grant=%0d valid=%b last=%b expected a5/5/1/1",
                     out_data, grant, out_valid, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            errors++;
            $display("FAIL fixed_drain: got valid=%b data=%h expected 0/a5", out_valid, out_data);
        end
        mode = 2'b11;
        set_ch(2, 1'b1, 8'h22, 1'b1);
        #1;
        checks++;
        if (in_ready !== 16'h0000) begin
            errors++;
            $display("FAIL reserved_mode_in_ready: got %h expected %h", in_ready, 16'h0000);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reserved_mode_out_valid: got %b expected 0", out_valid);
        end
        set_ch(2, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [6];
        exp_seq = '{4'd0, 4'd3, 4'd15, 4'd0, 4'd3, 4'd15};
        do_reset();
        mode = 2'b01;
        set_ch(0, 1'b1, 8'h10, 1'b1);
        set_ch(3, 1'b1, 8'h13, 1'b1);
        set_ch(15, 1'b1, 8'h1F, 1'b1);
        #1;
        checks++;
        if (in_ready !== 16'h0001) begin
            errors++;
            $display("FAIL rr_first_in_ready: got %h expected %h", in_ready, 16'h0001);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (grant !== exp_seq[i] || out_valid !== 1'b1 || out_data !== 8'h10 + 8'(exp_seq[i]))
            begin
                errors++;
                $display("FAIL rr_grant_%0d: got grant=%0d valid=%b data=%h expected %0d/1/%h",
                         i, grant, out_valid, out_data, exp_seq[i], 8'h10 + 8'(exp_seq[i]));
            end
        end
        set_ch(0, 1'b0, 8'h00, 1'b0);
        set_ch(3, 1'b0, 8'h00, 1'b0);
        set_ch(15, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_priority_lock();
        logic [7:0] beat [3];
        beat = '{8'h21, 8'h22, 8'h23};
        mode = 2'b10;
        for (int b = 0; b < 3; b++) begin
            set_ch(2, 1'b1, beat[b], b == 2);
            if (b == 1) set_ch(0, 1'b1, 8'h01, 1'b1);
            #1;
            checks++;
            if (in_ready !== 16'h0004) begin
                errors++;
                $display("FAIL lock_in_ready_beat%0d: got %h expected %h", b, in_ready, 16'h0004);
            end
            tick();
            checks++;
            if (grant !== 4'd2 || out_data !== beat[b] || out_last !== (b == 2)) begin
                errors++;
                $display("FAIL lock_beat%0d: got grant=%0d data=%h last=%b expected 2/%h/%b",
                         b, grant, out_data, out_last, beat[b], b == 2);
            end
        end
        set_ch(2, 1'b0, 8'h00, 1'b0);
        #1;
        checks++;
        if (in_ready !== 16'h0001) begin
            errors++;
            $display("FAIL lock_release_in_ready: got %h expected %h", in_ready, 16'h0001);
        end
        tick();
        checks++;
        if (grant !== 4'd0 || out_data !== 8'h01 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_release: got grant=%0d data=%h valid=%b expected 0/01/1",
                     grant, out_data, out_valid);
        end
        set_ch(0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        mode = 2'b10;
        set_ch(1, 1'b1, 8'h31, 1'b1);
        tick();
        out_ready = 1'b0;
        set_ch(1, 1'b1, 8'h32, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 16'h0000) begin
                errors++;
                $display("FAIL bp_in_ready_%0d: got %h expected %h", i, in_ready, 16'h0000);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h31 || grant !== 4'd1) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b data=%h grant=%0d expected 1/31/1",
                         i, out_valid, out_data, grant);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 16'h0002) begin
            errors++;
            $display("FAIL bp_release_in_ready: got %h expected %h", in_ready, 16'h0002);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h32 || grant !== 4'd1) begin
            errors++;
            $display("FAIL bp_no_bubble: got valid=%b data=%h grant=%0d expected 1/32/1",
                     out_valid, out_data, grant);
        end
        set_ch(1, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_packet();
        mode = 2'b01;
        set_ch(7, 1'b1, 8'h71, 1'b0);
        set_ch(1, 1'b1, 8'h11, 1'b1);
        #1;
        checks++;
        if (in_ready !== 16'h0080) begin
            errors++;
            $display("FAIL rstmid_first_in_ready: got %h expected %h", in_ready, 16'h0080);
        end
        tick();
        checks++;
        if (grant !== 4'd7 || out_data !== 8'h71 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_beat1: got grant=%0d data=%h valid=%b expected 7/71/1",
                     grant, out_data, out_valid);
        end
        set_ch(7, 1'b1, 8'h72, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_async: got valid=%b in_ready=%h expected 0/0000",
                     out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 16'h0002) begin
            errors++;
            $display("FAIL rstmid_after_in_ready: got %h expected %h", in_ready, 16'h0002);
        end
        tick();
        checks++;
        if (grant !== 4'd1 || out_data !== 8'h11 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ch1_first: got grant=%0d data=%h valid=%b expected 1/11/1",
                     grant, out_data, out_valid);
        end
        set_ch(1, 1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if (grant !== 4'd7 || out_data !== 8'h72) begin
            errors++;
            $display("FAIL rstmid_ch7_next: got grant=%0d data=%h expected 7/72", grant, out_data);
        end
        set_ch(7, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_round_robin();
        test_priority_lock();
        test_backpressure();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
